// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and index sizing.
// The index is sized for the widest legal operand (32 bits).
package serial_add_pkg;

    localparam int IDX_W = 5;

    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic idx_t last_idx(input int width);
        return idx_t'(width - 1);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages and a carry OR.
// Shared by every bit position of the serial adder.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    assign h1_s = a_i ^ b_i;
    assign h1_c = a_i & b_i;
    assign s_o  = h1_s ^ c_i;
    assign h2_c = h1_s & c_i;
    assign c_o  = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// One sum bit per ADD cycle through a single fa_cell, LSB first.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam idx_t LAST = last_idx(WIDTH);

    logic [1:0]       state_q, state_d;
    idx_t             idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic op_a;
    logic op_b;
    logic fa_s;
    logic fa_co;

    // Compare-based bit select keeps the index width independent of WIDTH.
    always_comb begin
        op_a = 1'b0;
        op_b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == idx_t'(i)) begin
                op_a = a_q[i];
                op_b = b_q[i];
            end
        end
    end

    fa_cell u_fa (
        .a_i (op_a),
        .b_i (op_b),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (idx_q == idx_t'(i)) begin
                        sum_d[i] = fa_s;
                    end
                end
                carry_d = fa_co;
                idx_d   = idx_q + idx_t'(1);
                if (idx_q == LAST) begin
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
// Expected results go through per-instance scoreboard queues.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       iv8 = 1'b0, ir8, ci8 = 1'b0, ov8, or8 = 1'b0, co8, bz8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       iv4 = 1'b0, ir4, ci4 = 1'b0, ov4, or4 = 1'b0, co4, bz4;
    logic [3:0] a4 = '0, b4 = '0, s4;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .busy(bz8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .busy(bz4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards pop on each output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) check("sb8_unexpected", 1, 0);
            else check("sb8_result", {23'd0, co8, s8}, {23'd0, q8.pop_front()});
        end
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) check("sb4_unexpected", 1, 0);
            else check("sb4_result", {27'd0, co4, s4}, {27'd0, q4.pop_front()});
        end
    end

    task automatic accept8(input logic [7:0] a, input logic [7:0] b,
                           input logic c, input bit push);
        int t;
        a8  = a;
        b8  = b;
        ci8 = c;
        iv8 = 1'b1;
        if (push) q8.push_back(9'(a) + 9'(b) + 9'(c));
        t = 0;
        while (!ir8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("acc8_ready", {31'd0, ir8}, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 1;
        while (!ov8 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("post_ovalid", {31'd0, ov8}, 0);
        check("post_iready", {31'd0, ir8}, 1);
    endtask

    initial begin
        int lat;
        int prev;
        int acc;
        int t;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_sum8",   {24'd0, s8}, 0);
        check("rst_cout8",  {31'd0, co8}, 0);
        check("rst_ov8",    {31'd0, ov8}, 0);
        check("rst_ir8",    {31'd0, ir8}, 1);
        check("rst_busy8",  {31'd0, bz8}, 0);
        check("rst_sum4",   {28'd0, s4}, 0);
        check("rst_ir4",    {31'd0, ir4}, 1);

        accept8(8'h00, 8'h00, 1'b0, 1'b1);
        check("busy_add", {31'd0, bz8}, 1);
        wait_done8(lat);
        check("lat_zero", lat, 9);
        consume8();

        accept8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done8(lat);
        check("lat_ripple", lat, 9);
        consume8();

        accept8(8'hA5, 8'h5A, 1'b1, 1'b1);
        wait_done8(lat);
        check("lat_a55a", lat, 9);
        consume8();

        // Hold result while new operands pulse on the input side.
        accept8(8'h3C, 8'h0F, 1'b0, 1'b1);
        wait_done8(lat);
        for (int i = 0; i < 5; i++) begin
            iv8 = (i % 2 == 0);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
            @(posedge clk); #1;
            check("hold_ov",   {31'd0, ov8}, 1);
            check("hold_sum",  {24'd0, s8}, 32'h4B);
            check("hold_cout", {31'd0, co8}, 0);
            check("hold_ir",   {31'd0, ir8}, 0);
        end
        iv8 = 1'b0;
        consume8();
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, bz8}, 0);
        check("idle_sum",  {24'd0, s8}, 32'h4B);
        check("sb8_drain", q8.size(), 0);

        // Abort an addition mid-flight.
        accept8(8'h77, 8'h11, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bz8}, 0);
        check("abort_sum",  {24'd0, s8}, 0);
        check("abort_cout", {31'd0, co8}, 0);
        check("abort_ov",   {31'd0, ov8}, 0);
        check("abort_ir",   {31'd0, ir8}, 1);

        accept8(8'h12, 8'h34, 1'b0, 1'b1);
        wait_done8(lat);
        check("lat_after_rst", lat, 9);
        check("sum_after_rst", {24'd0, s8}, 32'h46);
        consume8();

        // Exhaustive WIDTH=4 sweep with both handshakes held open.
        or4  = 1'b1;
        prev = 0;
        for (int i = 0; i < 512; i++) begin
            a4  = 4'(i >> 5);
            b4  = 4'(i >> 1);
            ci4 = 1'(i);
            iv4 = 1'b1;
            q4.push_back(5'(a4) + 5'(b4) + 5'(ci4));
            t = 0;
            while (!ir4 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) check("thr4", acc - prev, 6);
            prev = acc;
        end
        iv4 = 1'b0;
        t = 0;
        while (q4.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("sb4_drain", q4.size(), 0);
        check("sb8_final", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
